vga_sync: RTL
=============

VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 SHALL have port clk, input, 1 bit: 50 MHz system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port p_tick, output, 1 bit: 25 MHz pixel-enable strobe, high for exactly one clk cycle out of every two.
REQ-004 SHALL have port pix_x, output, 10 bits: current horizontal count, 0..799.
REQ-005 SHALL have port pix_y, output, 10 bits: current vertical count, 0..524.
REQ-006 SHALL have port video_on, output, 1 bit: high when the current pixel is inside the 640x480 visible area.
REQ-007 SHALL have port hsync, output, 1 bit: horizontal sync, active-low, registered.
REQ-008 SHALL have port vsync, output, 1 bit: vertical sync, active-low, registered.
REQ-009 SHALL have port frame_end, output, 1 bit: one-clk pulse on the last pixel of each frame.

Function
REQ-010 SHALL use horizontal timing of 640 display, 16 front porch, 96 sync and 48 back porch, for a total of 800 counts.
REQ-011 SHALL use vertical timing of 480 display, 10 front porch, 2 sync and 33 back porch, for a total of 525 lines.
REQ-012 SHALL generate p_tick from a 1-bit toggle register: 0 in the first clk after reset release, 1 in the second, alternating thereafter.
REQ-013 SHALL change h_count only in cycles where p_tick=1: increment by 1, or wrap 799->0.
REQ-014 SHALL change v_count only in cycles where p_tick=1 and h_count=799: increment by 1, or wrap 524->0.
REQ-015 SHALL handle the simultaneous wrap h=799, v=524, p_tick=1 by setting both counters to 0 on the same edge.
REQ-016 SHALL drive pix_x from h_count and pix_y from v_count directly, with no added latency.
REQ-017 SHALL compute video_on combinationally as (h_count<640) AND (v_count<480).
REQ-018 SHALL register hsync and vsync from the next-state counter values, so that hsync=0 exactly while pix_x is in 656..751 and vsync=0 exactly while pix_y is in 490..491, with zero cycle skew against pix_x/pix_y.
REQ-019 SHALL assert frame_end combinationally for one clk when p_tick=1, h_count=799 and v_count=524; it is never asserted in any other cycle.
REQ-020 SHALL keep counters below 800 and 525 respectively; if an out-of-range value is ever present, it wraps to 0 on the next p_tick.
REQ-021 SHALL keep all outputs stable while p_tick=0, except p_tick itself and frame_end.

Reset
REQ-022 SHALL, in any clk cycle where reset=1, load h_count=0, v_count=0, the tick toggle=0, hsync=1 and vsync=1.
REQ-023 SHALL hold the following output values while reset=1 and in the first cycle after release: p_tick=0, pix_x=0, pix_y=0, video_on=1, frame_end=0.
REQ-024 SHALL abandon the frame in progress on a mid-frame reset, and restart timing from (0,0) with the tick phase of REQ-012.

Structure
REQ-025 SHALL take the horizontal and vertical display, front porch, sync, back porch and total constants, plus sync-start/end values derived from them, from shared package vga_pkg, and no literal timing numbers SHALL appear in the module body.
REQ-026 SHALL implement the 25 MHz strobe (REQ-012) as sub-module vga_pixel_tick (ports clk, reset, tick); counters and sync logic SHALL be in vga_sync.
REQ-027 SHALL register pix_x/pix_y for direct use as text/graphics generator coordinates; pixel-generation stages SHALL consume them qualified by video_on.

Verification
REQ-028 Bench SHALL check reset then release: p_tick sequence 0,1,0,1 over the first 4 clks; pix_x reaches 1 at clk 3 and 2 at clk 5.
REQ-029 Bench SHALL check horizontal timing over one full line (1600 clks): hsync falls when pix_x becomes 656 and rises when pix_x becomes 752; video_on falls at pix_x=640; pix_x wraps 799->0 with pix_y incrementing by 1 on the same edge.
REQ-030 Bench SHALL check vertical timing over one frame (840000 clks): vsync low for exactly 2 lines (pix_y 490..491, 3200 clks); exactly one frame_end pulse, at pix_x=799, pix_y=524; both counters wrap to 0 on the next edge.
REQ-031 Bench SHALL check a mid-frame reset at pix_x=300, pix_y=200 for 3 clks: all outputs match REQ-023; the subsequent frame_end arrives exactly 840000 clks after release.
REQ-032 Bench SHALL check stability: assertions that pix_x/pix_y/hsync/vsync never change in cycles where p_tick was 0 on the previous edge, over 2 full frames.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and small helpers used by the
// sync generator and any downstream pixel-generation stages.
package vga_pkg;

  localparam int CNT_W = 10;

  typedef logic [CNT_W-1:0] count_t;

  localparam count_t CNT_ONE = count_t'(1);

  localparam count_t H_DISPLAY = count_t'(640);
  localparam count_t H_FRONT   = count_t'(16);
  localparam count_t H_SYNC    = count_t'(96);
  localparam count_t H_BACK    = count_t'(48);
  localparam count_t H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

  localparam count_t V_DISPLAY = count_t'(480);
  localparam count_t V_FRONT   = count_t'(10);
  localparam count_t V_SYNC    = count_t'(2);
  localparam count_t V_BACK    = count_t'(33);
  localparam count_t V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Sync windows are inclusive: pulse covers [START, END].
  localparam count_t H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam count_t H_SYNC_END   = H_SYNC_START + H_SYNC - CNT_ONE;
  localparam count_t V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam count_t V_SYNC_END   = V_SYNC_START + V_SYNC - CNT_ONE;

  localparam count_t H_MAX = H_TOTAL - CNT_ONE;
  localparam count_t V_MAX = V_TOTAL - CNT_ONE;

  function automatic logic in_window(count_t value, count_t lo, count_t hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Divide-by-two pixel enable: a single toggle flop that is low in the first
// clk after reset release and alternates thereafter.
module vga_pixel_tick (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  always_ff @(posedge clk) begin
    if (reset) begin
      tick <= 1'b0;
    end else begin
      tick <= ~tick;
    end
  end

endmodule

// File: rtl/vga_sync.sv
// VGA horizontal/vertical timing generator: pixel counters, registered
// active-low syncs aligned to the counters, visible-area flag and frame pulse.
module vga_sync
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  output logic             p_tick,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_end
);

  count_t h_count;
  count_t v_count;
  count_t h_next;
  count_t v_next;
  logic   h_last;
  logic   v_last;
  logic   hsync_q;
  logic   vsync_q;

  vga_pixel_tick u_pixel_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (p_tick)
  );

  // ">=" rather than "==" so a corrupted counter still wraps on the next tick.
  assign h_last = (h_count >= H_MAX);
  assign v_last = (v_count >= V_MAX);

  always_comb begin
    h_next = h_count;
    v_next = v_count;
    if (p_tick) begin
      h_next = h_last ? '0 : h_count + CNT_ONE;
      if (v_count > V_MAX) begin
        v_next = '0;
      end else if (h_last) begin
        v_next = v_last ? '0 : v_count + CNT_ONE;
      end
    end
  end

  // Syncs are decoded from the next-state counters so that the registered
  // pulse lines up with pix_x/pix_y on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      h_count <= h_next;
      v_count <= v_next;
      hsync_q <= ~in_window(h_next, H_SYNC_START, H_SYNC_END);
      vsync_q <= ~in_window(v_next, V_SYNC_START, V_SYNC_END);
    end
  end

  assign pix_x     = h_count;
  assign pix_y     = v_count;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign video_on  = (h_count < H_DISPLAY) && (v_count < V_DISPLAY);
  assign frame_end = p_tick && (h_count == H_MAX) && (v_count == V_MAX);

endmodule
